// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with in-order read return
//
// Shares one data-memory port between port 0 (CPU LSU) and port 1 (aux master).
// Port 0 has priority. Port 1 is forced a grant once it has been denied
// STARVE_LIMIT consecutive cycles. Read data comes back on the port that issued
// the read, READ_LATENCY cycles after the grant. Responses return in issue order.
//
// Optional macro DMEM_ARB_LOCK_EN: adds p1_lock_i, which lets port 1 hold the
// memory for up to LOCK_MAX cycles. A forced lock exit is followed by one
// cooldown cycle in which port 1 cannot relock.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   pN_req_i/we_i/addr_i/wdata_i/be_i   request side of port N (0, 1)
//   pN_gnt_o                       port N accepted this cycle (combinational)
//   pN_rvalid_o/rdata_o            read response of port N
//   p1_lock_i                      port 1 lock request (DMEM_ARB_LOCK_EN only)
//   mem_en_o/we_o/addr_o/wdata_o/be_o   memory request (mux of the winner)
//   mem_rdata_i                    memory read data, valid READ_LATENCY after issue
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
`ifdef DMEM_ARB_LOCK_EN
  , parameter int LOCK_MAX   = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [XLEN-1:0]   p0_addr_i,
  input  logic [XLEN-1:0]   p0_wdata_i,
  input  logic [XLEN/8-1:0] p0_be_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [XLEN-1:0]   p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [XLEN-1:0]   p1_addr_i,
  input  logic [XLEN-1:0]   p1_wdata_i,
  input  logic [XLEN/8-1:0] p1_be_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [XLEN-1:0]   p1_rdata_o,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              p1_lock_i,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  logic [7:0] starve_q, starve_d;
  logic       starved;
  logic       lock_hold;

  // Read return pipeline: valid bit and owner (1 = port 1) per stage.
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0] rd_own_q, rd_own_d;
  logic [XLEN-1:0]         p0_rdata_q, p0_rdata_d;
  logic [XLEN-1:0]         p1_rdata_q, p1_rdata_d;

  assign starved = (starve_q == 8'(STARVE_LIMIT));

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {UNLOCKED, LOCKED, COOLDOWN} lock_state_e;
  lock_state_e state_q, state_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;

  // Dropping p1_lock_i releases the memory in the same cycle.
  assign lock_hold = (state_q == LOCKED) && p1_lock_i;
`else
  assign lock_hold = 1'b0;
`endif

  // Grant is gated by reset so nothing reaches memory while rst_i is low.
  always_comb begin
    p0_gnt_o = 1'b0;
    p1_gnt_o = 1'b0;
    if (rst_i) begin
      if (lock_hold) begin
        p1_gnt_o = p1_req_i;
      end else if (p1_req_i && (!p0_req_i || starved)) begin
        p1_gnt_o = 1'b1;
      end else begin
        p0_gnt_o = p0_req_i;
      end
    end
  end

  always_comb begin
    mem_en_o    = p0_gnt_o | p1_gnt_o;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (p1_gnt_o) begin
      mem_we_o    = p1_we_i;
      mem_addr_o  = p1_addr_i;
      mem_wdata_o = p1_wdata_i;
      mem_be_o    = p1_be_i;
    end else if (p0_gnt_o) begin
      mem_we_o    = p0_we_i;
      mem_addr_o  = p0_addr_i;
      mem_wdata_o = p0_wdata_i;
      mem_be_o    = p0_be_i;
    end
  end

  always_comb begin
    starve_d = 8'd0;
    if (p1_req_i && !p1_gnt_o) begin
      starve_d = starved ? starve_q : starve_q + 8'd1;
    end
  end

  always_comb begin
    rd_vld_d    = '0;
    rd_own_d    = '0;
    rd_vld_d[0] = (p0_gnt_o && !p0_we_i) || (p1_gnt_o && !p1_we_i);
    rd_own_d[0] = p1_gnt_o;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_own_d[i] = rd_own_q[i-1];
    end
  end

  assign p0_rvalid_o = rd_vld_q[READ_LATENCY-1] && !rd_own_q[READ_LATENCY-1];
  assign p1_rvalid_o = rd_vld_q[READ_LATENCY-1] &&  rd_own_q[READ_LATENCY-1];

  // Memory data passes straight through on the owner's port; the other port
  // keeps presenting the last data it received.
  assign p0_rdata_d = p0_rvalid_o ? mem_rdata_i : p0_rdata_q;
  assign p1_rdata_d = p1_rvalid_o ? mem_rdata_i : p1_rdata_q;
  assign p0_rdata_o = p0_rdata_d;
  assign p1_rdata_o = p1_rdata_d;

`ifdef DMEM_ARB_LOCK_EN
  // lock_cnt counts cycles spent owning the memory, including the grant that
  // took the lock.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (p1_gnt_o && p1_lock_i) begin
          lock_cnt_d = 16'd1;
          state_d    = (16'(LOCK_MAX) <= 16'd1) ? COOLDOWN : LOCKED;
        end
      end
      LOCKED: begin
        if (!p1_lock_i) begin
          state_d    = UNLOCKED;
          lock_cnt_d = 16'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
          if (lock_cnt_d >= 16'(LOCK_MAX)) begin
            state_d    = COOLDOWN;
            lock_cnt_d = 16'd0;
          end
        end
      end
      COOLDOWN: state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_q   <= 8'd0;
      rd_vld_q   <= '0;
      rd_own_q   <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_vld_q   <= rd_vld_d;
      rd_own_q   <= rd_own_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0_req_i, p0_we_i;
  logic [31:0] p0_addr_i, p0_wdata_i;
  logic [3:0]  p0_be_i;
  logic        p0_gnt_o, p0_rvalid_o;
  logic [31:0] p0_rdata_o;
  logic        p1_req_i, p1_we_i;
  logic [31:0] p1_addr_i, p1_wdata_i;
  logic [3:0]  p1_be_i;
  logic        p1_gnt_o, p1_rvalid_o;
  logic [31:0] p1_rdata_o;
  logic        p1_lock_i;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .XLEN(32), .READ_LATENCY(1), .STARVE_LIMIT(8)
`ifdef DMEM_ARB_LOCK_EN
    , .LOCK_MAX(4)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
    .p0_wdata_i(p0_wdata_i), .p0_be_i(p0_be_i), .p0_gnt_o(p0_gnt_o),
    .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
    .p1_wdata_i(p1_wdata_i), .p1_be_i(p1_be_i), .p1_gnt_o(p1_gnt_o),
    .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
`ifdef DMEM_ARB_LOCK_EN
    .p1_lock_i(p1_lock_i),
`endif
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  // Memory model with one cycle read latency; idle cycles return a marker.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en_o && !mem_we_o) begin
      mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
    end else begin
      mem_rdata_i <= 32'hBAD0BAD0;
    end
    if (mem_en_o && mem_we_o) begin
      logic [31:0] w;
      w = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
      end
      mem[mem_addr_o] = w;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (p0_rvalid_o || p1_rvalid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rvalid: got p0=%b p1=%b expected none (cycle %0d)",
                   p0_rvalid_o, p1_rvalid_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rvalid_port", {30'd0, p1_rvalid_o, p0_rvalid_o}, e.port ? 32'd2 : 32'd1);
          chk("rdata", e.port ? p1_rdata_o : p0_rdata_o, e.data);
          chk("rvalid_cycle", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_rvalid: got none expected port %0d data %h (cycle %0d)",
                 exp_q[0].port, exp_q[0].data, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drv0(input logic req, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    p0_req_i = req; p0_we_i = we; p0_addr_i = a; p0_wdata_i = d; p0_be_i = be;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    p1_req_i = req; p1_we_i = we; p1_addr_i = a; p1_wdata_i = d; p1_be_i = be;
  endtask

  // Checks the grants of the current cycle, queues the expected read response
  // (if any) and advances to just after the next rising edge.
  task automatic step(input logic eg0, input logic eg1, input logic push,
                      input logic [31:0] data);
    exp_t e;
    @(negedge clk);
    chk("p0_gnt", {31'd0, p0_gnt_o}, {31'd0, eg0});
    chk("p1_gnt", {31'd0, p1_gnt_o}, {31'd0, eg1});
    chk("mem_en", {31'd0, mem_en_o}, {31'd0, eg0 | eg1});
    if (push) begin
      e.port = eg1;
      e.data = data;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_p0_gnt", {31'd0, p0_gnt_o}, 32'd0);
    chk("rst_p1_gnt", {31'd0, p1_gnt_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid_o}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid_o}, 32'd0);
    chk("rst_p0_rdata", p0_rdata_o, 32'd0);
    chk("rst_p1_rdata", p1_rdata_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h20] = 32'hA5A50020;
    mem[32'h24] = 32'h5A5A0024;
    p1_lock_i   = 1'b0;
    rst_i       = 1'b0;
    // Requests held during reset must not leak through.
    drv0(1'b1, 1'b1, 32'h10, 32'h11111111, 4'hF);
    drv1(1'b1, 1'b1, 32'h24, 32'h22222222, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // p0 read of 0x10 alone.
    drv0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    chk("p0_rd_mem_addr", mem_addr_o, 32'h10);
    chk("p0_rd_mem_we", {31'd0, mem_we_o}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // p0 read 0x20 then p1 read 0x24 the next cycle.
    drv0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    step(1'b1, 1'b0, 1'b1, 32'hA5A50020);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv1(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b1, 32'h5A5A0024);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("p0_rdata_hold", p0_rdata_o, 32'hA5A50020);

    // p1 write, then p0 reads it back.
    drv1(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    #1;
    chk("wr_mem_we", {31'd0, mem_we_o}, 32'd1);
    chk("wr_mem_addr", mem_addr_o, 32'h40);
    chk("wr_mem_wdata", mem_wdata_o, 32'h12345678);
    chk("wr_mem_be", {28'd0, mem_be_o}, 32'hF);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    step(1'b1, 1'b0, 1'b1, 32'h12345678);

    // Both ports requesting: p0 wins 8 cycles, p1 forced on the 9th.
    drv1(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    drv0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 18; i++) begin
      if ((i % 9) == 8) step(1'b0, 1'b1, 1'b1, 32'h5A5A0024);
      else              step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    end
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Short reset pulse while a read is in flight drops the response.
    drv0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b0;
    #2;
    chk_reset_outputs();
    #1;
    rst_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

`ifdef DMEM_ARB_LOCK_EN
    // p1 takes the lock, holds it 4 cycles, p0 gets the cooldown, p1 relocks.
    p1_lock_i = 1'b1;
    drv1(1'b1, 1'b1, 32'h80, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    drv0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    drv0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    p1_lock_i = 1'b0;
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
`endif

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
